// File: rtl/card_shuffler.sv
//==============================================================================
// Module  : card_shuffler
// Purpose : Builds a 52-card deck, Fisher-Yates shuffles it with a 16-bit LFSR
//           and streams the cards over valid/ready. Optional: CARD_SHUFFLER_CHECK_EN
// Revision: 1.0
//==============================================================================
`default_nettype none

module card_shuffler #(
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int          CARD_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              seed_load,
    input  logic [15:0]       seed_in,
    output logic [CARD_W-1:0] card_out,
    output logic              card_valid,
    input  logic              card_ready,
    output logic              busy,
    output logic              done
`ifdef CARD_SHUFFLER_CHECK_EN
    ,
    output logic              dup_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BUILD   = 3'd1,
        S_SHUFFLE = 3'd2,
        S_STREAM  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [5:0]        idx;
    logic [5:0]        idx_inc;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_nxt;
    logic [5:0]        j;
    logic              ctrl_ok;
    logic              start_ok;
    logic              accept;
    logic              xfer;
    logic [CARD_W-1:0] build_card;
    logic [CARD_W-1:0] fwd_card;
    logic [CARD_W-1:0] deck [0:51];

    assign j          = lfsr[5:0];
    assign idx_inc    = idx + 6'd1;
    assign ctrl_ok    = (state == S_IDLE) || (state == S_DONE);
    assign start_ok   = start && ctrl_ok;
    assign accept     = (j <= idx);
    assign xfer       = card_valid && card_ready;
    assign lfsr_nxt   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign build_card = {idx[5:2] + 4'd1, idx[1:0], 1'b0};
    // Final swap (i==1) may move deck[1] into slot 0 on the same edge card_out loads
    assign fwd_card   = (j == 6'd0) ? deck[1] : deck[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start_ok) state_nxt = S_BUILD;
            S_BUILD:        if (idx == 6'd51) state_nxt = S_SHUFFLE;
            S_SHUFFLE:      if (accept && (idx == 6'd1)) state_nxt = S_STREAM;
            S_STREAM:       if (xfer && (idx == 6'd51)) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx        <= 6'd0;
            lfsr       <= SEED;
            card_out   <= '0;
            card_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state_nxt == S_BUILD) || (state_nxt == S_SHUFFLE) || (state_nxt == S_STREAM);
            done <= (state_nxt == S_DONE);

            if (seed_load && ctrl_ok) begin
                lfsr <= (seed_in == 16'd0) ? SEED : seed_in;
            end else begin
                lfsr <= lfsr_nxt;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) idx <= 6'd0;
                end
                S_BUILD: begin
                    idx <= (idx == 6'd51) ? 6'd51 : idx_inc;
                end
                S_SHUFFLE: begin
                    if (accept) begin
                        if (idx == 6'd1) begin
                            idx        <= 6'd0;
                            card_valid <= 1'b1;
                            card_out   <= fwd_card;
                        end else begin
                            idx <= idx - 6'd1;
                        end
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        if (idx == 6'd51) begin
                            idx        <= 6'd0;
                            card_valid <= 1'b0;
                            card_out   <= '0;
                        end else begin
                            idx      <= idx_inc;
                            card_out <= deck[idx_inc];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Deck storage carries no reset; its contents are rebuilt on every run
    always_ff @(posedge clk) begin
        if (state == S_BUILD) begin
            deck[idx] <= build_card;
        end else if ((state == S_SHUFFLE) && accept) begin
            deck[idx] <= deck[j];
            deck[j]   <= deck[idx];
        end
    end

`ifdef CARD_SHUFFLER_CHECK_EN
    logic [51:0] seen;
    logic [3:0]  xr;
    logic [1:0]  xs;
    logic [5:0]  bitpos;

    assign xr     = card_out[6:3];
    assign xs     = card_out[2:1];
    assign bitpos = {xr - 4'd1, xs};

    always_ff @(posedge clk) begin
        if (!rst) begin
            seen    <= '0;
            dup_err <= 1'b0;
        end else if (start_ok) begin
            seen    <= '0;
            dup_err <= 1'b0;
        end else if (xfer) begin
            if ((xr == 4'd0) || (xr > 4'd13)) begin
                dup_err <= 1'b1;
            end else begin
                if (seen[bitpos]) dup_err <= 1'b1;
                seen[bitpos] <= 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_card_shuffler.sv
//==============================================================================
// Module  : tb_card_shuffler
// Purpose : Scoreboard bench for card_shuffler (deck model + transfer monitor)
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_card_shuffler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [6:0]  card_out;
    logic        card_valid;
    logic        card_ready;
    logic        busy;
    logic        done;
`ifdef CARD_SHUFFLER_CHECK_EN
    logic        dup_err;
`endif

    always #5 clk = ~clk;

    card_shuffler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .card_out   (card_out),
        .card_valid (card_valid),
        .card_ready (card_ready),
        .busy       (busy),
        .done       (done)
`ifdef CARD_SHUFFLER_CHECK_EN
        ,
        .dup_err    (dup_err)
`endif
    );

    int         checks   = 0;
    int         failures = 0;
    logic [6:0] exp_q [$];
    logic [6:0] got_q [$];
    logic [6:0] seq_a [$];
    logic [6:0] mdl [52];
    logic [6:0] exp_card;
    int         xfers    = 0;
    logic       bp_en    = 1'b0;
    int         rdy_cnt  = 0;
    logic [3:0] rdy_pat  = 4'b1001;
    logic       stall_prev = 1'b0;
    logic [6:0] card_prev  = 7'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference: ordered deck, LFSR from the start edge, 52 build steps, then Fisher-Yates
    task automatic make_model(input logic [15:0] s, input int extra);
        logic [15:0] l;
        logic [6:0]  t;
        int          i;
        int          jj;
        int          guard;
        for (int c = 0; c < 52; c++) mdl[c] = {4'(c / 4 + 1), 2'(c % 4), 1'b0};
        l = (s == 16'd0) ? 16'hACE1 : s;
        for (int n = 0; n < extra + 52; n++) l = adv(l);
        i = 51;
        guard = 0;
        while (i >= 1 && guard < 100000) begin
            jj = int'(l[5:0]);
            if (jj <= i) begin
                t       = mdl[i];
                mdl[i]  = mdl[jj];
                mdl[jj] = t;
                i--;
            end
            l = adv(l);
            guard++;
        end
    endtask

    initial begin
        card_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                card_ready = rdy_pat[rdy_cnt % 4] ^ ($urandom_range(0, 7) == 0);
                rdy_cnt++;
            end else begin
                card_ready = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (stall_prev) begin
                    check("stall_valid", 64'(card_valid), 64'd1);
                    check("stall_hold", 64'(card_out), 64'(card_prev));
                end
                if (card_valid && card_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_xfer actual=%0h required=none", card_out);
                    end else begin
                        exp_card = exp_q.pop_front();
                        check("card", 64'(card_out), 64'(exp_card));
                    end
                    got_q.push_back(card_out);
                    xfers++;
                end
                stall_prev = card_valid && !card_ready;
                card_prev  = card_out;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_multiset(input string tag);
        logic [51:0] mask;
        int          dups;
        logic [3:0]  r;
        mask = '0;
        dups = 0;
        foreach (got_q[n]) begin
            r = got_q[n][6:3];
            if (r >= 4'd1 && r <= 4'd13 && got_q[n][0] == 1'b0) begin
                if (mask[{r - 4'd1, got_q[n][2:1]}]) dups++;
                mask[{r - 4'd1, got_q[n][2:1]}] = 1'b1;
            end
        end
        check({tag, "_multiset"}, 64'(mask), 64'({52{1'b1}}));
        check({tag, "_dups"}, 64'(dups), 64'd0);
    endtask

    task automatic run(input logic do_seed, input logic [15:0] s, input int extra,
                       input logic bp, input logic busy_pulse, input int reset_at,
                       input string tag);
        int   cyc;
        logic finished;
        logic p2;
        make_model(s, extra);
        exp_q.delete();
        for (int c = 0; c < 52; c++) exp_q.push_back(mdl[c]);
        got_q.delete();
        xfers     = 0;
        bp_en     = bp;
        start     = 1'b1;
        seed_load = do_seed;
        seed_in   = s;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        check({tag, "_done_cleared"}, 64'(done), 64'd0);
        cyc      = 0;
        finished = 1'b0;
        p2       = 1'b0;
        while (!finished && cyc < 4000) begin
            if (done) begin
                finished = 1'b1;
            end else begin
                start = 1'b0;
                if (busy_pulse && cyc == 60) begin
                    check({tag, "_in_shuffle"}, 64'({busy, card_valid}), 64'b10);
                    start = 1'b1;
                end
                if (busy_pulse && !p2 && xfers >= 10) begin
                    start = 1'b1;
                    p2    = 1'b1;
                end
                if (reset_at >= 0 && xfers >= reset_at) begin
                    rst = 1'b0;
                    tick();
                    check({tag, "_rst_valid"}, 64'(card_valid), 64'd0);
                    check({tag, "_rst_busy"}, 64'(busy), 64'd0);
                    check({tag, "_rst_card"}, 64'(card_out), 64'd0);
                    exp_q.delete();
                    bp_en = 1'b0;
                    return;
                end
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        bp_en = 1'b0;
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", tag);
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_valid_low"}, 64'(card_valid), 64'd0);
        check({tag, "_card_zero"}, 64'(card_out), 64'd0);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        check({tag, "_xfers"}, 64'(xfers), 64'd52);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check_multiset(tag);
`ifdef CARD_SHUFFLER_CHECK_EN
        check({tag, "_dup_err"}, 64'(dup_err), 64'd0);
`endif
    endtask

    function automatic int same_as_a();
        if (got_q.size() != seq_a.size()) return 0;
        foreach (got_q[n]) if (got_q[n] !== seq_a[n]) return 0;
        return 1;
    endfunction

    initial begin
        rst       = 1'b0;
        start     = 1'b1;
        seed_load = 1'b0;
        seed_in   = 16'd0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("reset_valid", 64'(card_valid), 64'd0);
            check("reset_busy", 64'(busy), 64'd0);
            check("reset_done", 64'(done), 64'd0);
            check("reset_card", 64'(card_out), 64'd0);
        end
        rst   = 1'b1;
        start = 1'b0;
        repeat (5) tick();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_valid", 64'(card_valid), 64'd0);
        check("idle_done", 64'(done), 64'd0);

        run(1'b1, 16'h1234, 0, 1'b0, 1'b0, -1, "full");
        seq_a = got_q;
        repeat (3) tick();
        run(1'b1, 16'h1234, 0, 1'b0, 1'b0, -1, "repeat");
        check("determinism_same", 64'(same_as_a()), 64'd1);
        run(1'b1, 16'h1235, 0, 1'b0, 1'b0, -1, "seed1235");
        check("seed_differs", 64'(same_as_a()), 64'd0);

        run(1'b1, 16'hBEEF, 0, 1'b1, 1'b0, -1, "backpressure");

        run(1'b1, 16'h0000, 0, 1'b0, 1'b0, -1, "zero_seed");
        run(1'b1, 16'h5A5A, 0, 1'b0, 1'b0, 20, "mid_reset");
        rst = 1'b1;
        run(1'b0, 16'h0000, 1, 1'b0, 1'b0, -1, "post_reset");

        run(1'b1, 16'h7777, 0, 1'b0, 1'b1, -1, "start_busy");

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
